// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared constants and helpers for the FIFO stream reader
package fifo_stream_pkg;

    localparam int STAT_WIDTH = 32;

    // One slot per outstanding pop plus one so a full pipe can keep issuing while the head waits
    function automatic int buf_depth(input int rd_latency);
        return rd_latency + 1;
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// rtl/stream_skid_buffer.sv - WIDTH x DEPTH register FIFO with same-cycle push/pop
module stream_skid_buffer #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 3,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage is cleared on reset so the head reads zero while empty after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side consumer with credit-checked pops (stats: FIFO_STREAM_READER_STATS_EN)
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic [WIDTH-1:0]      fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [STAT_WIDTH-1:0] stat_words,
    output logic [STAT_WIDTH-1:0] stat_stalls
);

    localparam int BUF_DEPTH = buf_depth(RD_LATENCY);
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int OCC_W     = $clog2(2 * BUF_DEPTH + 1);

    logic [RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0]      buf_count;
    logic [OCC_W-1:0]      occ, occ_net;
    logic                  consume;
    logic                  land;

    assign consume = out_valid && out_ready;
    assign land    = inflight_q[RD_LATENCY-1];

    // Every pop already issued owns a buffer slot; a word leaving this cycle frees one
    always_comb begin
        occ = OCC_W'(buf_count);
        for (int i = 0; i < RD_LATENCY; i++) begin
            occ = occ + OCC_W'(inflight_q[i]);
        end
        occ_net    = occ - OCC_W'(consume);
        fifo_rd_en = rst_n && !fifo_rd_empty && (occ_net < OCC_W'(BUF_DEPTH));
    end

    always_comb begin
        inflight_d    = '0;
        inflight_d[0] = fifo_rd_en;
        for (int i = 1; i < RD_LATENCY; i++) begin
            inflight_d[i] = inflight_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    stream_skid_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (land),
        .push_data_i (fifo_rd_data),
        .pop_i       (consume),
        .head_o      (out_data),
        .count_o     (buf_count)
    );

    assign out_valid = (buf_count != '0);

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [STAT_WIDTH-1:0] words_q, words_d;
    logic [STAT_WIDTH-1:0] stalls_q, stalls_d;

    always_comb begin
        words_d  = words_q + STAT_WIDTH'(consume);
        stalls_d = stalls_q + STAT_WIDTH'(out_valid && !out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q  <= '0;
            stalls_q <= '0;
        end else begin
            words_q  <= words_d;
            stalls_q <= stalls_d;
        end
    end

    assign stat_words  = words_q;
    assign stat_stalls = stalls_q;
`else
    assign stat_words  = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader at RD_LATENCY 2 and 1
module tb_fifo_stream_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        rd_en0, rd_en1, empty0, empty1;
    logic        valid0, valid1, ready0, ready1, gate_empty;
    logic [15:0] rd_data0, rd_data1, data0, data1;
    logic [31:0] sw0, ss0, sw1, ss1;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural FIFO read ports: lane 0 has 2-cycle read latency, lane 1 has 1
    logic [15:0] fmem0 [4096];
    logic [15:0] fmem1 [4096];
    int          wr_idx0 = 0, wr_idx1 = 0, rd_idx0 = 0, rd_idx1 = 0;
    logic [15:0] pa0 = 16'h0, pb0 = 16'h0, pa1 = 16'h0;

    assign empty0   = (rd_idx0 >= wr_idx0) || gate_empty;
    assign empty1   = (rd_idx1 >= wr_idx1);
    assign rd_data0 = pb0;
    assign rd_data1 = pa1;

    always @(posedge clk) begin
        if (rd_en0) begin
            pa0     <= fmem0[rd_idx0];
            rd_idx0 <= rd_idx0 + 1;
        end else begin
            pa0 <= 16'hDEAD;
        end
        pb0 <= pa0;
        if (rd_en1) begin
            pa1     <= fmem1[rd_idx1];
            rd_idx1 <= rd_idx1 + 1;
        end else begin
            pa1 <= 16'hBEEF;
        end
    end

    fifo_stream_reader #(.WIDTH(16), .RD_LATENCY(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_rd_en    (rd_en0),
        .fifo_rd_data  (rd_data0),
        .fifo_rd_empty (empty0),
        .out_valid     (valid0),
        .out_ready     (ready0),
        .out_data      (data0),
        .stat_words    (sw0),
        .stat_stalls   (ss0)
    );

    fifo_stream_reader #(.WIDTH(16), .RD_LATENCY(1)) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_rd_en    (rd_en1),
        .fifo_rd_data  (rd_data1),
        .fifo_rd_empty (empty1),
        .out_valid     (valid1),
        .out_ready     (ready1),
        .out_data      (data1),
        .stat_words    (sw1),
        .stat_stalls   (ss1)
    );

    logic [15:0] got0 [$];
    logic [15:0] got1 [$];
    int pops0 = 0, pops1 = 0, viol = 0, assert_bad = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid0 && ready0) got0.push_back(data0);
            if (valid1 && ready1) got1.push_back(data1);
            if (rd_en0) pops0++;
            if (rd_en1) pops1++;
            if (dut.buf_count > 3 || dut1.buf_count > 2) begin
                assert_bad++;
                $display("FAIL buf_count_bound: lane0=%0d (max 3) lane1=%0d (max 2)", dut.buf_count, dut1.buf_count);
            end
        end
        if ((rd_en0 && empty0) || (rd_en1 && empty1)) viol++;
    end

    task automatic push0(input logic [15:0] w);
        fmem0[wr_idx0] = w;
        wr_idx0++;
    endtask

    task automatic push1(input logic [15:0] w);
        fmem1[wr_idx1] = w;
        wr_idx1++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rd_en0 !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", rd_en0); end
        n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid0); end
        n_cmp++; if (data0 !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0000", data0); end
        n_cmp++; if (sw0 !== 32'h0) begin n_bad++; $display("FAIL reset_stat_words: got %0d want 0", sw0); end
        n_cmp++; if (ss0 !== 32'h0) begin n_bad++; $display("FAIL reset_stat_stalls: got %0d want 0", ss0); end
        n_cmp++; if (valid1 !== 1'b0 || data1 !== 16'h0) begin n_bad++; $display("FAIL reset_lane1: valid %b data %h want 0/0000", valid1, data1); end
    endtask

    task automatic test_preload_stream();
        logic [19:0] en_vec, v_vec;
        logic [15:0] d [20];
        do_reset();
        ready0 = 1'b1;
        for (int i = 1; i <= 8; i++) push0(16'(i));
        @(negedge clk);
        n_cmp++; if (rd_en0 !== 1'b0) begin n_bad++; $display("FAIL rd_en_in_reset: got %b want 0", rd_en0); end
        release_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            en_vec[c] = rd_en0;
            v_vec[c]  = valid0;
            d[c]      = data0;
        end
        n_cmp++; if (en_vec !== 20'h000FF) begin n_bad++; $display("FAIL preload_rd_en_pattern: got %h want 000ff", en_vec); end
        n_cmp++; if (v_vec !== 20'h007F8) begin n_bad++; $display("FAIL preload_valid_pattern: got %h want 007f8", v_vec); end
        for (int c = 3; c <= 10; c++) begin
            n_cmp++;
            if (d[c] !== 16'(c - 2)) begin n_bad++; $display("FAIL preload_data[%0d]: got %h want %h", c, d[c], 16'(c - 2)); end
        end
    endtask

    task automatic test_backpressure();
        int p0, gs, unstable;
        do_reset();
        ready0 = 1'b0;
        for (int i = 1; i <= 8; i++) push0(16'(i));
        p0 = pops0;
        gs = got0.size();
        unstable = 0;
        release_reset();
        repeat (20) begin
            @(negedge clk);
            if (valid0 && data0 !== 16'h0001) unstable++;
        end
        @(posedge clk); #1;
        n_cmp++; if (pops0 - p0 != 3) begin n_bad++; $display("FAIL bp_pop_count: got %0d want 3", pops0 - p0); end
        n_cmp++; if (valid0 !== 1'b1 || data0 !== 16'h0001) begin n_bad++; $display("FAIL bp_head: valid %b data %h want 1/0001", valid0, data0); end
        n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL bp_data_stable: got %0d changes want 0", unstable); end
        ready0 = 1'b1;
        for (int c = 0; c < 200 && (got0.size() - gs) < 8; c++) begin @(posedge clk); #1; end
        n_cmp++; if (got0.size() - gs != 8) begin n_bad++; $display("FAIL bp_delivered: got %0d want 8", got0.size() - gs); end
        for (int i = 0; i < 8 && gs + i < got0.size(); i++) begin
            n_cmp++;
            if (got0[gs + i] !== 16'(i + 1)) begin n_bad++; $display("FAIL bp_word[%0d]: got %h want %h", i, got0[gs + i], 16'(i + 1)); end
        end
    endtask

    task automatic test_random();
        int b0, b1, g0, g1, bad0, bad1;
        b0 = wr_idx0; b1 = wr_idx1;
        g0 = got0.size(); g1 = got1.size();
        for (int i = 0; i < 1000; i++) begin
            push0(16'($urandom));
            push1(16'($urandom));
        end
        for (int c = 0; c < 8000 && ((got0.size() - g0) < 1000 || (got1.size() - g1) < 1000); c++) begin
            @(posedge clk); #1;
            ready0 = 1'($urandom_range(0, 1));
            ready1 = 1'($urandom_range(0, 1));
        end
        ready0 = 1'b1; ready1 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bad0 = 0; bad1 = 0;
        for (int i = 0; i < 1000 && g0 + i < got0.size(); i++) if (got0[g0 + i] !== fmem0[b0 + i]) bad0++;
        for (int i = 0; i < 1000 && g1 + i < got1.size(); i++) if (got1[g1 + i] !== fmem1[b1 + i]) bad1++;
        n_cmp++; if (got0.size() - g0 != 1000) begin n_bad++; $display("FAIL rand_count_lat2: got %0d want 1000", got0.size() - g0); end
        n_cmp++; if (got1.size() - g1 != 1000) begin n_bad++; $display("FAIL rand_count_lat1: got %0d want 1000", got1.size() - g1); end
        n_cmp++; if (bad0 != 0) begin n_bad++; $display("FAIL rand_order_lat2: got %0d wrong words want 0", bad0); end
        n_cmp++; if (bad1 != 0) begin n_bad++; $display("FAIL rand_order_lat1: got %0d wrong words want 0", bad1); end
    endtask

    task automatic test_empty_toggle();
        int b0, g0, p0, v0, bad;
        ready0 = 1'b1;
        b0 = wr_idx0; g0 = got0.size(); p0 = pops0; v0 = viol;
        for (int i = 0; i < 20; i++) push0(16'($urandom));
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            gate_empty = ~gate_empty;
        end
        gate_empty = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < 20 && g0 + i < got0.size(); i++) if (got0[g0 + i] !== fmem0[b0 + i]) bad++;
        n_cmp++; if (viol != v0) begin n_bad++; $display("FAIL toggle_pop_while_empty: got %0d want 0", viol - v0); end
        n_cmp++; if (got0.size() - g0 != pops0 - p0) begin n_bad++; $display("FAIL toggle_delivered_vs_pops: got %0d want %0d", got0.size() - g0, pops0 - p0); end
        n_cmp++; if (got0.size() - g0 != 20) begin n_bad++; $display("FAIL toggle_delivered: got %0d want 20", got0.size() - g0); end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL toggle_order: got %0d wrong words want 0", bad); end
    endtask

    task automatic test_reset_midflight();
        int p0, g0;
        do_reset();
        ready0 = 1'b0;
        for (int i = 1; i <= 7; i++) push0(16'h0100 + 16'(i));
        p0 = pops0; g0 = got0.size();
        release_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (valid0 !== 1'b1 || pops0 - p0 != 3) begin n_bad++; $display("FAIL mid_pre_state: valid %b pops %0d want 1/3", valid0, pops0 - p0); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (valid0 !== 1'b0 || data0 !== 16'h0) begin n_bad++; $display("FAIL mid_async_clear: valid %b data %h want 0/0000", valid0, data0); end
        n_cmp++; if (rd_en0 !== 1'b0) begin n_bad++; $display("FAIL mid_rd_en: got %b want 0", rd_en0); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL mid_valid_held: got %b want 0", valid0); end
        ready0 = 1'b1;
        rst_n  = 1'b1;
        for (int c = 0; c < 100 && (got0.size() - g0) < 4; c++) begin @(posedge clk); #1; end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (got0.size() - g0 != 4) begin n_bad++; $display("FAIL mid_delivered: got %0d want 4", got0.size() - g0); end
        for (int i = 0; i < 4 && g0 + i < got0.size(); i++) begin
            n_cmp++;
            if (got0[g0 + i] !== 16'h0104 + 16'(i)) begin n_bad++; $display("FAIL mid_word[%0d]: got %h want %h", i, got0[g0 + i], 16'h0104 + 16'(i)); end
        end
    endtask

    task automatic test_stats();
        int g0;
        logic [31:0] exp_w, exp_s;
`ifdef FIFO_STREAM_READER_STATS_EN
        exp_w = 32'd10; exp_s = 32'd4;
`else
        exp_w = 32'd0;  exp_s = 32'd0;
`endif
        do_reset();
        ready0 = 1'b0;
        for (int i = 0; i < 10; i++) push0(16'($urandom));
        g0 = got0.size();
        release_reset();
        for (int c = 0; c < 20 && !valid0; c++) begin @(posedge clk); #1; end
        repeat (4) @(posedge clk);
        #1;
        ready0 = 1'b1;
        for (int c = 0; c < 100 && (got0.size() - g0) < 10; c++) begin @(posedge clk); #1; end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (got0.size() - g0 != 10) begin n_bad++; $display("FAIL stats_delivered: got %0d want 10", got0.size() - g0); end
        n_cmp++; if (sw0 !== exp_w) begin n_bad++; $display("FAIL stat_words: got %0d want %0d", sw0, exp_w); end
        n_cmp++; if (ss0 !== exp_s) begin n_bad++; $display("FAIL stat_stalls: got %0d want %0d", ss0, exp_s); end
    endtask

    initial begin
        ready0 = 1'b1;
        ready1 = 1'b1;
        gate_empty = 1'b0;
        test_reset();
        test_preload_stream();
        test_backpressure();
        test_random();
        test_empty_toggle();
        test_reset_midflight();
        test_stats();
        n_cmp++; if (assert_bad != 0) begin n_bad++; $display("FAIL buf_count_assert: got %0d hits want 0", assert_bad); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side consumer for the team's cross-clock FIFO. It runs in the FIFO's read clock domain, issues `fifo_rd_en` pops only while it has buffer space for the returning word, and absorbs the fixed memory read latency. It presents the data as a valid/ready stream, sustaining one word per cycle under no backpressure and never dropping or duplicating a word under arbitrary `out_ready` patterns.

## Interface
- `WIDTH`, 16, data word width; must match the FIFO's width.
- `RD_LATENCY`, 2, cycles from a `fifo_rd_en`-high cycle to valid `fifo_rd_data`: 1 without the output register, 2 with it. Legal range 1..4.
- `clk` input 1: the FIFO read clock; all logic is on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `fifo_rd_en` output 1: pop strobe to the FIFO read port.
- `fifo_rd_data` input WIDTH: FIFO read data.
- `fifo_rd_empty` input 1: FIFO empty flag.
- `out_valid` output 1: `out_data` holds a word.
- `out_ready` input 1: the downstream block accepts the word.
- `out_data` output WIDTH: stream data.
- `stat_words` output 32: count of words delivered. Present only with the stats feature.
- `stat_stalls` output 32: count of backpressure cycles. Present only with the stats feature.

## Operation
- Local constant `BUF_DEPTH = RD_LATENCY + 1`.
- Internal state:
  - `inflight` pipe: a RD_LATENCY-bit shift register marking which past cycles issued a pop.
  - Skid buffer: a synchronous FIFO of BUF_DEPTH × WIDTH.
  - `buf_count`: buffer occupancy, 0..BUF_DEPTH.
- Occupancy is `occ = buf_count + popcount(inflight)`. Use enough bits to hold 2·BUF_DEPTH.
- `fifo_rd_en` is combinational: `rst_n && !fifo_rd_empty && (occ - (out_valid && out_ready)) < BUF_DEPTH`.
- The inflight pipe shifts in `fifo_rd_en` every cycle. When the oldest bit is 1, `fifo_rd_data` is written into the buffer that cycle.
- `out_valid = (buf_count != 0)`. `out_data` is the buffer head. A word is consumed on `out_valid && out_ready`.
- Buffer write and read in the same cycle are legal: `buf_count` is unchanged and order is preserved.
- Buffer overflow is unreachable by construction. The bench asserts `buf_count <= BUF_DEPTH` every cycle.
- While `out_valid` is high and `out_ready` is low, `out_data` is held stable.
- Reset asserted at any time:
  - Inflight pipe and buffer are cleared; `out_valid` goes to 0 and `out_data` to 0 asynchronously.
  - `fifo_rd_en` goes to 0 immediately.
  - Words popped but not yet delivered are discarded. The FIFO pointers are not rewound.

## Timing
- Reset values: `fifo_rd_en` 0, `out_valid` 0, `out_data` 0, `stat_words` 0, `stat_stalls` 0.
- The first `fifo_rd_en` can occur in the first cycle after `rst_n` deasserts.
- Latency: a pop in cycle N gives `out_valid` in cycle N + RD_LATENCY + 1.
- Throughput: with `out_ready` held at 1 and the FIFO non-empty, `fifo_rd_en` is high every cycle and `out_valid` is continuous.
- With `out_ready` held at 0, at most BUF_DEPTH pops are issued. `fifo_rd_en` then stays 0 until a word is consumed.
- `fifo_rd_en` responds to `fifo_rd_empty` in the same cycle.

## Configuration
- Macro: `FIFO_STREAM_READER_STATS_EN`.
- Defined:
  - `stat_words` increments on each `out_valid && out_ready`.
  - `stat_stalls` increments on each `out_valid && !out_ready`.
  - Both are 32-bit, wrap modulo 2^32, and clear on reset.
- Undefined: the counter logic is omitted and both ports are driven constant 0.

## Structure
- Package `fifo_stream_pkg` holds `STAT_WIDTH = 32` and the function `buf_depth(rd_latency)`, which returns rd_latency + 1.
- One sub-module, `stream_skid_buffer`. It is a parameterised WIDTH × DEPTH register FIFO with push/pop/count ports, async active-low reset, and same-cycle push+pop support.
- The top level holds the inflight pipe, the credit check and the stats counters.

## Test plan
- Reset release, RD_LATENCY=2, FIFO preloaded with 0x0001..0x0008, `out_ready`=1: `fifo_rd_en` is high for 8 consecutive cycles. `out_valid` first rises 3 cycles after the first pop, then is high for 8 consecutive cycles carrying 0x0001..0x0008 in order.
- Same preload, `out_ready`=0 for 20 cycles: exactly 3 pops are issued, `out_valid`=1 and `out_data`=0x0001 stable. After `out_ready`→1, all 8 words are delivered in order.
- Random `out_ready` (50%) over 1000 words, RD_LATENCY 1 and 2: the output sequence equals the input sequence. The `buf_count <= BUF_DEPTH` assertion never fires.
- `fifo_rd_empty` toggling every other cycle: no `fifo_rd_en` while empty. The delivered word count equals the number of pops.
- `rst_n` pulsed low with 2 words in flight and 1 buffered: `out_valid` is 0 during reset. After release only subsequent FIFO words appear, and the 3 dropped words are not emitted.
- With `FIFO_STREAM_READER_STATS_EN` defined, 10 words delivered with 4 stall cycles: `stat_words`=10 and `stat_stalls`=4. Without the macro, both read 0.
